idct_2d: RTL and testbench

IDCT_2D -- requirements
Module: idct_2d

---
 rtl/idct_2d_if.sv | 28 ++
 rtl/idct_2d.sv | 207 ++++++++++++++++++++
 tb/tb_idct_2d.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idct_2d_if.sv
// Block-level handshake bundle for idct_2d: one 8x8 coefficient block in,
// one 8x8 spatial block out, each with its own valid/ready pair.
interface idct_2d_if;
    logic        INPUT_DATA_ENABLE;
    logic        INPUT_READY;
    logic [31:0] INPUT_DATA [8][8];
    logic        OUTPUT_DATA_ENABLE;
    logic        OUTPUT_READY;
    logic [31:0] OUTPUT_DATA [8][8];

    modport master (
        output INPUT_DATA_ENABLE,
        output INPUT_DATA,
        output OUTPUT_READY,
        input  INPUT_READY,
        input  OUTPUT_DATA_ENABLE,
        input  OUTPUT_DATA
    );

    modport slave (
        input  INPUT_DATA_ENABLE,
        input  INPUT_DATA,
        input  OUTPUT_READY,
        output INPUT_READY,
        output OUTPUT_DATA_ENABLE,
        output OUTPUT_DATA
    );
endinterface

// File: rtl/idct_2d.sv
// 8x8 two-dimensional inverse DCT: eight row passes then eight column passes,
// one 1-D transform per cycle, in place in a 64-word working buffer.
module idct_2d #(
    parameter int COEF_FRAC = 13
) (
    input  logic     CLOCK,
    input  logic     RESET,
    idct_2d_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [7:0][31:0]  vec_t;
    typedef logic [63:0][31:0] tab_t;

    // Cosine table T[n][k] at index n*8+k; the angle is folded into the first
    // quadrant so only cos(m*pi/16), m = 0..8, is needed.
    function automatic tab_t build_tab();
        tab_t tab;
        real  cosv [9];
        real  scale;
        real  mag;
        int   m;
        int   val;
        logic neg;
        cosv[0] = 1.0;
        cosv[1] = 0.98078528040323044913;
        cosv[2] = 0.92387953251128675613;
        cosv[3] = 0.83146961230254523708;
        cosv[4] = 0.70710678118654752440;
        cosv[5] = 0.55557023301960222474;
        cosv[6] = 0.38268343236508977173;
        cosv[7] = 0.19509032201612826785;
        cosv[8] = 0.0;
        scale = 1.0;
        for (int i = 32'sd0; i < COEF_FRAC; i++) begin
            scale = scale * 2.0;
        end
        tab = '0;
        for (int n = 32'sd0; n < 32'sd8; n++) begin
            for (int k = 32'sd0; k < 32'sd8; k++) begin
                m   = ((32'sd2 * n + 32'sd1) * k) % 32'sd32;
                neg = 1'b0;
                if (m > 32'sd16) begin
                    m = 32'sd32 - m;
                end
                if (m > 32'sd8) begin
                    m   = 32'sd16 - m;
                    neg = 1'b1;
                end
                if (k == 32'sd0) begin
                    mag = cosv[m] * 0.35355339059327376220 * scale;
                end else begin
                    mag = cosv[m] * 0.5 * scale;
                end
                val = $rtoi(mag + 0.5);
                if (neg) begin
                    val = -val;
                end
                tab[n * 32'sd8 + k] = val;
            end
        end
        return tab;
    endfunction

    localparam tab_t COEF_TAB = build_tab();

    // One 1-D pass: 64-bit products and sum, round-half-up, floor shift, keep low 32 bits.
    function automatic vec_t idct_1d(input vec_t vin);
        vec_t              vout;
        logic signed [63:0] acc;
        logic signed [63:0] a_v;
        logic signed [63:0] t_v;
        for (int n = 32'sd0; n < 32'sd8; n++) begin
            acc = 64'sd0;
            for (int k = 32'sd0; k < 32'sd8; k++) begin
                a_v = 64'($signed(vin[k]));
                t_v = 64'($signed(COEF_TAB[n * 32'sd8 + k]));
                acc = acc + a_v * t_v;
            end
            acc     = acc + (64'sd1 <<< (COEF_FRAC - 32'sd1));
            acc     = acc >>> COEF_FRAC;
            vout[n] = acc[31:0];
        end
        return vout;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  cnt_r;
    logic [31:0] work_r [8][8];
    logic        ready_r;
    logic        oen_r;
    logic        accept_s;
    vec_t        vin_s;
    vec_t        vout_s;

    assign accept_s = bus.INPUT_DATA_ENABLE & ready_r;

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ROW;
                end else begin
                    state_s = IDLE;
                end
            end
            ROW: begin
                if (cnt_r == 3'd7) begin
                    state_s = COL;
                end else begin
                    state_s = ROW;
                end
            end
            COL: begin
                if (cnt_r == 3'd7) begin
                    state_s = DONE;
                end else begin
                    state_s = COL;
                end
            end
            DONE: begin
                if (bus.OUTPUT_READY) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Select the buffer row or column feeding the 1-D transform
    always_comb begin
        vin_s = '0;
        case (state_r)
            ROW: begin
                for (int k = 32'sd0; k < 32'sd8; k++) begin
                    vin_s[k] = work_r[cnt_r][k];
                end
            end
            COL: begin
                for (int k = 32'sd0; k < 32'sd8; k++) begin
                    vin_s[k] = work_r[k][cnt_r];
                end
            end
            default: vin_s = '0;
        endcase
    end

    assign vout_s = idct_1d(vin_s);

    // State, pass counter and registered handshake flags
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            ready_r <= 1'b0;
            oen_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == IDLE);
            oen_r   <= (state_s == DONE);
            case (state_r)
                ROW, COL: cnt_r <= cnt_r + 3'd1;
                default:  cnt_r <= 3'd0;
            endcase
        end
    end

    // Working buffer: block capture, then in-place row and column write-back
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            work_r <= '{default: 32'd0};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        work_r <= bus.INPUT_DATA;
                    end
                end
                ROW: begin
                    for (int k = 32'sd0; k < 32'sd8; k++) begin
                        work_r[cnt_r][k] <= vout_s[k];
                    end
                end
                COL: begin
                    for (int k = 32'sd0; k < 32'sd8; k++) begin
                        work_r[k][cnt_r] <= vout_s[k];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.INPUT_READY        = ready_r;
    assign bus.OUTPUT_DATA_ENABLE = oen_r;
    assign bus.OUTPUT_DATA        = work_r;
endmodule

// File: tb/tb_idct_2d.sv
// Directed bench for idct_2d: reset, DC/zero/hand-computed blocks, back-pressure,
// reset mid-column and back-to-back blocks against a floating-point-built table model.
module tb_idct_2d;
    localparam int COEF_FRAC = 13;

    logic CLOCK = 1'b0;
    logic RESET;

    idct_2d_if bus ();

    idct_2d #(.COEF_FRAC(COEF_FRAC)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] blk_in  [8][8];
    longint      tbl     [8][8];
    logic [31:0] blk_set [3][8][8];
    logic [31:0] exp_set [3][8][8];

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clear_blk();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                blk_in[y][x] = 32'd0;
    endtask

    task automatic init_table();
        real pi;
        real ck;
        real v;
        real scale;
        pi = 3.14159265358979323846;
        scale = 1.0;
        for (int i = 0; i < COEF_FRAC; i++) scale = scale * 2.0;
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 8; k++) begin
                ck = (k == 0) ? $sqrt(0.125) : 0.5;
                v  = ck * $cos(real'((2 * n + 1) * k) * pi / 16.0) * scale;
                if (v >= 0.0) tbl[n][k] = longint'($rtoi(v + 0.5));
                else          tbl[n][k] = -longint'($rtoi(-v + 0.5));
            end
        end
    endtask

    task automatic model_block(input int b);
        longint      acc;
        logic [31:0] mid [8][8];
        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < 8; n++) begin
                acc = 64'sd0;
                for (int k = 0; k < 8; k++)
                    acc = acc + longint'($signed(blk_set[b][r][k])) * tbl[n][k];
                acc = acc + (64'sd1 <<< (COEF_FRAC - 1));
                acc = acc >>> COEF_FRAC;
                mid[r][n] = acc[31:0];
            end
        end
        for (int c = 0; c < 8; c++) begin
            for (int n = 0; n < 8; n++) begin
                acc = 64'sd0;
                for (int k = 0; k < 8; k++)
                    acc = acc + longint'($signed(mid[k][c])) * tbl[n][k];
                acc = acc + (64'sd1 <<< (COEF_FRAC - 1));
                acc = acc >>> COEF_FRAC;
                exp_set[b][n][c] = acc[31:0];
            end
        end
    endtask

    // Present blk_in, wait for the accept edge, scramble the input, then count
    // cycles until OUTPUT_DATA_ENABLE is seen (bounded).
    task automatic send_block(output int lat);
        int guard;
        bus.INPUT_DATA        = blk_in;
        bus.INPUT_DATA_ENABLE = 1'b1;
        guard = 0;
        while (bus.INPUT_READY !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL accept_timeout: INPUT_READY=%b required 1", bus.INPUT_READY);
        end
        tick();
        bus.INPUT_DATA_ENABLE = 1'b0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                bus.INPUT_DATA[y][x] = 32'h5A5A_0000 + 32'(y * 8 + x);
        lat = 0;
        while (bus.OUTPUT_DATA_ENABLE !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        int bad;
        RESET = 1'b1;
        bus.INPUT_DATA_ENABLE = 1'b0;
        bus.OUTPUT_READY      = 1'b0;
        clear_blk();
        bus.INPUT_DATA = blk_in;
        repeat (3) tick();
        checks++;
        if (bus.INPUT_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0", bus.INPUT_READY);
        end
        checks++;
        if (bus.OUTPUT_DATA_ENABLE !== 1'b0) begin
            errors++;
            $display("FAIL reset_oen: got %b required 0", bus.OUTPUT_DATA_ENABLE);
        end
        bad = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (bus.OUTPUT_DATA[y][x] !== 32'd0) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_data: %0d nonzero words, required 0", bad);
        end
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.INPUT_READY !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", bus.INPUT_READY);
        end
        tick();
        checks++;
        if (bus.INPUT_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b required 1", bus.INPUT_READY);
        end
    endtask

    // Single coefficient at F[0][0]: every output equals expv.
    task automatic test_dc(input int coef, input int expv, input string name);
        int lat;
        clear_blk();
        blk_in[0][0] = 32'(coef);
        bus.OUTPUT_READY = 1'b1;
        send_block(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL %s_latency: got %0d required 16", name, lat);
        end
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                checks++;
                if (bus.OUTPUT_DATA[y][x] !== 32'(expv)) begin
                    errors++;
                    $display("FAIL %s_data[%0d][%0d]: got %0d required %0d",
                             name, y, x, $signed(bus.OUTPUT_DATA[y][x]), expv);
                end
            end
        end
        tick();
        checks++;
        if (bus.OUTPUT_DATA_ENABLE !== 1'b0) begin
            errors++;
            $display("FAIL %s_oen_one_cycle: got %b required 0", name, bus.OUTPUT_DATA_ENABLE);
        end
        checks++;
        if (bus.INPUT_READY !== 1'b1) begin
            errors++;
            $display("FAIL %s_back_to_idle: INPUT_READY=%b required 1", name, bus.INPUT_READY);
        end
    endtask

    // F[0][1]=8192: row 0 becomes T[n][1], each column then scales by T[0][0].
    task automatic test_horizontal();
        int lat;
        int hv [8];
        hv = '{1420, 1204, 805, 282, -282, -805, -1204, -1420};
        clear_blk();
        blk_in[0][1] = 32'd8192;
        bus.OUTPUT_READY = 1'b1;
        send_block(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL horiz_latency: got %0d required 16", lat);
        end
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                checks++;
                if (bus.OUTPUT_DATA[y][x] !== 32'(hv[x])) begin
                    errors++;
                    $display("FAIL horiz_data[%0d][%0d]: got %0d required %0d",
                             y, x, $signed(bus.OUTPUT_DATA[y][x]), hv[x]);
                end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        clear_blk();
        blk_in[0][0] = 32'd64;
        bus.OUTPUT_READY = 1'b0;
        send_block(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL bp_latency: got %0d required 16", lat);
        end
        bus.INPUT_DATA_ENABLE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.OUTPUT_DATA_ENABLE !== 1'b1) begin
                errors++;
                $display("FAIL bp_oen_hold cycle %0d: got %b required 1", i, bus.OUTPUT_DATA_ENABLE);
            end
            checks++;
            if (bus.INPUT_READY !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_low cycle %0d: got %b required 0", i, bus.INPUT_READY);
            end
            bad = 0;
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    if (bus.OUTPUT_DATA[y][x] !== 32'd8) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL bp_data_stable cycle %0d: %0d words differ from 8", i, bad);
            end
        end
        bus.INPUT_DATA_ENABLE = 1'b0;
        bus.OUTPUT_READY      = 1'b1;
        tick();
        checks++;
        if (bus.OUTPUT_DATA_ENABLE !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_oen: got %b required 0", bus.OUTPUT_DATA_ENABLE);
        end
        checks++;
        if (bus.INPUT_READY !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_idle: INPUT_READY=%b required 1", bus.INPUT_READY);
        end
    endtask

    task automatic test_reset_mid_col();
        int bad;
        int pulses;
        clear_blk();
        blk_in[0][0] = 32'd64;
        bus.OUTPUT_READY      = 1'b1;
        bus.INPUT_DATA        = blk_in;
        bus.INPUT_DATA_ENABLE = 1'b1;
        tick();
        bus.INPUT_DATA_ENABLE = 1'b0;
        repeat (11) tick();
        RESET = 1'b1;
        #1;
        bad = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (bus.OUTPUT_DATA[y][x] !== 32'd0) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midcol_reset_data: %0d nonzero words, required 0", bad);
        end
        checks++;
        if (bus.OUTPUT_DATA_ENABLE !== 1'b0 || bus.INPUT_READY !== 1'b0) begin
            errors++;
            $display("FAIL midcol_reset_flags: oen=%b ready=%b required 0 0",
                     bus.OUTPUT_DATA_ENABLE, bus.INPUT_READY);
        end
        tick();
        tick();
        RESET = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.OUTPUT_DATA_ENABLE !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midcol_no_pulse: %0d cycles with oen high, required 0", pulses);
        end
        test_dc(64, 8, "dc_after_reset");
    endtask

    task automatic test_back_to_back();
        int  acc_cyc [3];
        int  n_acc;
        int  n_out;
        bit  accepting;
        for (int b = 0; b < 3; b++) begin
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    blk_set[b][y][x] = 32'((((y * 8 + x) * 613 + b * 1777 + 91) % 4097) - 2048);
            model_block(b);
        end
        acc_cyc = '{-100, -200, -300};
        n_acc = 0;
        n_out = 0;
        bus.OUTPUT_READY      = 1'b1;
        bus.INPUT_DATA        = blk_set[0];
        bus.INPUT_DATA_ENABLE = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            accepting = (bus.INPUT_READY === 1'b1) && (bus.INPUT_DATA_ENABLE === 1'b1);
            if (accepting && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (bus.OUTPUT_DATA_ENABLE === 1'b1) begin
                if (n_out < 3) begin
                    for (int y = 0; y < 8; y++) begin
                        for (int x = 0; x < 8; x++) begin
                            checks++;
                            if (bus.OUTPUT_DATA[y][x] !== exp_set[n_out][y][x]) begin
                                errors++;
                                $display("FAIL b2b_blk%0d[%0d][%0d]: got %0d required %0d", n_out, y, x,
                                         $signed(bus.OUTPUT_DATA[y][x]), $signed(exp_set[n_out][y][x]));
                            end
                        end
                    end
                end
                n_out++;
            end
            tick();
            if (accepting) begin
                if (n_acc < 3) begin
                    bus.INPUT_DATA = blk_set[n_acc];
                end else begin
                    bus.INPUT_DATA_ENABLE = 1'b0;
                    for (int y = 0; y < 8; y++)
                        for (int x = 0; x < 8; x++)
                            bus.INPUT_DATA[y][x] = 32'h0BAD_0000 + 32'(x);
                end
            end
        end
        checks++;
        if (n_acc !== 3) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d required 3", n_acc);
        end
        checks++;
        if (n_out !== 3) begin
            errors++;
            $display("FAIL b2b_outputs: got %0d required 3", n_out);
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 18) begin
            errors++;
            $display("FAIL b2b_spacing_01: got %0d required 18", acc_cyc[1] - acc_cyc[0]);
        end
        checks++;
        if (acc_cyc[2] - acc_cyc[1] !== 18) begin
            errors++;
            $display("FAIL b2b_spacing_12: got %0d required 18", acc_cyc[2] - acc_cyc[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_table();
        test_reset();
        test_dc(64, 8, "dc_pos");
        test_dc(-64, -8, "dc_neg");
        test_dc(0, 0, "zero");
        test_horizontal();
        test_backpressure();
        test_reset_mid_col();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
